// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the hardened UART receiver
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 87;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_e;
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: 2-flop line synchroniser and 3-sample majority voter
module uart_bit_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_bit,
  input  logic sample,
  input  logic decide,
  output logic rx_s,
  output logic bit_v
);
  logic s1_q, s2_q;
  logic [1:0] samp_q, samp_d;
  assign rx_s  = s2_q;
  assign bit_v = maj3({samp_q, rx_s});
  // the third sample is the live value at decision time, so history clears once voted
  always_comb samp_d = decide ? 2'b00 : sample ? {samp_q[0], rx_s} : samp_q;
  // synchroniser resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      samp_q <= 2'b00;
    end else begin
      s1_q   <= rx_bit;
      s2_q   <= s1_q;
      samp_q <= samp_d;
    end
  end
endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: 8N1 receiver with majority voting, false-start and framing checks, valid/ready output
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  output logic [DATA_BITS-1:0] data_word,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  if (CLKS_PER_BIT < 8) begin : g_cpb_chk
    $error("CLKS_PER_BIT must be >= 8");
  end
  if (DATA_BITS != 8) begin : g_db_chk
    $error("DATA_BITS is fixed at 8");
  end
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, word_q, word_d;
  logic deliver_q, deliver_d, valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic rx_s, bit_v, in_frame, sample, decide, load;
  assign in_frame = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign sample   = in_frame && cnt_q >= CW'(HALF - 1) && cnt_q <= CW'(HALF + 1);
  assign decide   = in_frame && cnt_q == CW'(HALF + 1);
  assign data_word  = word_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign rx_busy    = state_q != IDLE;
  uart_bit_sampler u_samp (
    .clk   (clk),
    .rst   (rst),
    .rx_bit(rx_bit),
    .sample(sample),
    .decide(decide),
    .rx_s  (rx_s),
    .bit_v (bit_v)
  );
  // frame FSM: the bit counter free-wraps from the start edge so every decision lands mid-bit
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    sh_d      = sh_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (decide) begin
        state_d = bit_v ? IDLE : DATA;
        idx_d   = 3'd0;
      end
      DATA: if (decide) begin
        sh_d  = {bit_v, sh_q[DATA_BITS-1:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (decide) begin
        state_d   = bit_v ? IDLE : BREAK_WAIT;
        deliver_d = bit_v;
        ferr_d    = !bit_v;
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // holding register: a full, unaccepted register drops the new byte and flags overrun
  always_comb begin
    load   = deliver_q && (!valid_q || data_ready);
    word_d = load ? sh_q : word_q;
    valid_d = load || (valid_q && !data_ready);
    ovr_d  = deliver_q && valid_q && !data_ready;
  end
  // state and output registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      sh_q      <= '0;
      word_q    <= '0;
      deliver_q <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      word_q    <= word_d;
      deliver_q <= deliver_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: serial-line driver with byte scoreboard and frame-level vector table
module tb_uart_rx_ovs;
  localparam int CPB = 87;
  typedef struct {
    logic [7:0] d;
    bit         ok;
    int         ev;
    int         ef;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rx_bit = 1'b1, data_ready = 1'b1;
  logic [7:0] data_word;
  logic data_valid, frame_err, overrun, rx_busy;
  logic [7:0] q[$];
  logic [7:0] e;
  int n_cmp = 0, n_bad = 0, n_acc = 0, n_ferr = 0, n_ovr = 0;
  always #5 clk = ~clk;
  uart_rx_ovs #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_bit    (rx_bit),
    .data_word (data_word),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive_bit(input logic v, input int n);
    rx_bit = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input bit stop_ok, input int spike);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++)
      if (i == spike) begin
        drive_bit(d[i], 45);
        drive_bit(~d[i], 1);
        drive_bit(d[i], CPB - 46);
      end else drive_bit(d[i], CPB);
    drive_bit(stop_ok, CPB);
  endtask
  always @(negedge clk) if (!rst) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (frame_err || overrun) chk("err_exclusive", 32'(frame_err & overrun), 0);
    if (data_valid && data_ready) begin
      n_acc++;
      if (q.size() == 0) chk("unexpected_byte", 32'(data_word), 32'h100);
      else begin
        e = q.pop_front();
        chk("byte", 32'(data_word), 32'(e));
      end
    end
  end
  initial begin
    vec_t tbl[5];
    int lat, a, f, o;
    logic [7:0] d;
    tbl[0] = '{8'h3C, 1'b1, 1, 0};
    tbl[1] = '{8'h3C, 1'b0, 0, 1};
    tbl[2] = '{8'h5A, 1'b1, 1, 0};
    tbl[3] = '{8'hE7, 1'b0, 0, 1};
    tbl[4] = '{8'h96, 1'b1, 1, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", 32'(data_word), 0);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_busy", 32'(rx_busy), 0);
    rst = 1'b0;
    drive_bit(1'b1, 20);
    q.push_back(8'hA5);
    fork
      send(8'hA5, 1'b1, -1);
      begin
        lat = 0;
        while (!data_valid && lat < 2000) begin
          @(posedge clk);
          #1;
          lat++;
        end
        n_cmp++;
        if (lat < 830 || lat > 834) begin
          n_bad++;
          $display("FAIL latency: got %0d cycles expected 832 +/-2", lat);
        end
        @(posedge clk);
        #1;
        chk("valid_one_cycle", 32'(data_valid), 0);
      end
    join
    drive_bit(1'b1, CPB);
    chk("loop_ferr", n_ferr, 0);
    chk("loop_ovr", n_ovr, 0);
    for (int i = 0; i < 5; i++) begin
      a = n_acc;
      f = n_ferr;
      if (tbl[i].ok) q.push_back(tbl[i].d);
      send(tbl[i].d, tbl[i].ok, -1);
      if (!tbl[i].ok) begin
        drive_bit(1'b0, 2 * CPB);
        chk("break_busy", 32'(rx_busy), 1);
      end
      drive_bit(1'b1, 2 * CPB);
      chk("tbl_valid", n_acc - a, tbl[i].ev);
      chk("tbl_ferr", n_ferr - f, tbl[i].ef);
      chk("tbl_idle", 32'(rx_busy), 0);
    end
    a = n_acc;
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 30);
    chk("glitch_busy", 32'(rx_busy), 0);
    q.push_back(8'h3C);
    send(8'h3C, 1'b1, -1);
    drive_bit(1'b1, CPB);
    chk("glitch_then_byte", n_acc - a, 1);
    data_ready = 1'b0;
    o = n_ovr;
    q.push_back(8'h11);
    send(8'h11, 1'b1, -1);
    send(8'h22, 1'b1, -1);
    drive_bit(1'b1, CPB);
    chk("ovr_pulse", n_ovr - o, 1);
    chk("ovr_word", 32'(data_word), 32'h11);
    chk("ovr_valid", 32'(data_valid), 1);
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_drop_valid", 32'(data_valid), 0);
    chk("ovr_word_hold", 32'(data_word), 32'h11);
    a = n_acc;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    q.push_back(8'h81);
    send(8'h00, 1'b1, -1);
    send(8'hFF, 1'b1, -1);
    send(8'h81, 1'b1, 3);
    drive_bit(1'b1, 2 * CPB);
    chk("b2b_count", n_acc - a, 3);
    a = n_acc;
    d = 8'h77;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
    drive_bit(d[4], 40);
    rst = 1'b1;
    rx_bit = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_word", 32'(data_word), 0);
    chk("mid_rst_valid", 32'(data_valid), 0);
    chk("mid_rst_busy", 32'(rx_busy), 0);
    chk("mid_rst_ferr", 32'(frame_err), 0);
    drive_bit(1'b1, 2 * CPB);
    chk("mid_rst_no_byte", n_acc - a, 0);
    q.push_back(8'hC3);
    send(8'hC3, 1'b1, -1);
    drive_bit(1'b1, 2 * CPB);
    chk("after_rst_byte", n_acc - a, 1);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
- Hardened UART receive end, paired with uart_tx on the same serial line.
- 8N1 frames, LSB first; sits between the serial pin and the byte-consumer logic.
- Adds input synchronisation, 3-sample majority voting, false-start rejection, framing-error detection and a valid/ready byte handshake with overrun reporting.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per bit (10 MHz / 115200); must be >= 8, checked by elaboration assertion.
- DATA_BITS, 8, data bits per frame; fixed at 8 in this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_bit  input  1  asynchronous serial line, idle high.
- data_word  output  8  received byte; stable while data_valid=1.
- data_valid  output  1  byte available; held until accepted.
- data_ready  input  1  consumer accepts the byte when data_valid && data_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, applied on a clk edge with rst=1:
  - state=IDLE; counters=0.
  - Synchroniser flops=1.
  - data_word=0x00; data_valid=0; frame_err=0; overrun=0; rx_busy=0.
  - Reset mid-frame abandons the frame with no error pulse and no partial byte.
- Input synchronisation:
  - rx_bit passes through 2 flops; all decisions use the synchronised value rx_s.
  - Added latency: 2 cycles.
- Timing within each bit:
  - Bit counter runs 0..CLKS_PER_BIT-1; HALF = CLKS_PER_BIT/2 (integer divide).
  - Samples are taken at counts HALF-1, HALF and HALF+1.
  - Majority of the 3 samples is the bit value, decided at count HALF+1.
  - Counter width is $clog2(CLKS_PER_BIT).
- State machine:
  - IDLE: rx_s==0 → START with counter cleared.
  - START: at HALF+1, majority==1 → IDLE (glitch rejected, no outputs). Majority==0 → DATA.
    - The counter continues to wrap, so later decisions fall at mid-bit.
  - DATA: each bit decision shifts into the shift register LSB-first; bit index 0..7.
    - After the bit-7 decision → STOP.
  - STOP: at HALF+1, majority==1 → deliver the byte, then IDLE.
    - IDLE is re-entered at mid-stop-bit, so back-to-back frames are received.
  - STOP: majority==0 → frame_err=1 for 1 cycle, byte discarded → BREAK_WAIT.
  - BREAK_WAIT: stays until rx_s==1, then IDLE.
- Delivery happens the cycle after the stop decision:
  - If data_valid==0: data_word←byte, data_valid←1.
  - If data_valid==1 and data_ready==1 in the same cycle: new byte loaded, data_valid stays 1, no overrun.
  - If data_valid==1 and data_ready==0: overrun=1 for 1 cycle; new byte dropped; old data_word retained.
- Handshake:
  - data_valid && data_ready with no simultaneous delivery → data_valid←0 next cycle.
  - data_word holds its last value after acceptance.
- Latency: first sync low sample to data_valid ≈ 9*CLKS_PER_BIT + HALF + 4 cycles. The exact figure is measured and checked by the bench with ±2 tolerance.
- frame_err and overrun are never both high in the same cycle.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK_WAIT}.
  - DATA_BITS=8.
  - CLKS_PER_BIT_DEFAULT=87.
- Sub-module uart_bit_sampler:
  - Contains the 2-flop synchroniser and the 3-sample majority voter.
  - Inputs: clk, rst, rx_bit, a sample strobe and a decide strobe.
  - Outputs: rx_s and the voted bit.
- The top level holds the FSM, counters, shift register and output handshake.

Test Plan:
- Loopback: uart_tx (CLKS_PER_BIT=87) sends 0xA5 with data_ready=1 → data_valid pulses 1 cycle, data_word=0xA5, frame_err=0, overrun=0.
- Glitch: rx_bit low for 20 cycles, then high → no data_valid, rx_busy returns low by cycle ~45. Then 0x3C is received correctly.
- Framing error: drive 0x3C with stop bit=0, line held low for 2 further bits, then high → one frame_err pulse, no data_valid, state BREAK_WAIT until high. A following 0x5A is delivered.
- Overrun: data_ready=0, send 0x11 then 0x22 → data_word=0x11, one overrun pulse at the second stop. Raise data_ready → 0x11 accepted, data_valid drops.
- Back-to-back: 0x00, 0xFF, 0x81 with no idle gap, data_ready=1 → three valid bytes in order. Also apply a 1-cycle spike inverted at count HALF of bit 3 of 0x81 → still 0x81 (majority).
- Reset mid-frame: assert rst for 1 cycle during bit 4 of 0x77 → outputs 0 the next cycle, no partial byte. A following 0xC3 is received correctly.
